// File: rtl/seven_seg_scan_mux_if.sv
// Display-side bundle for the 7-segment scanner: shadow-load inputs and registered pin drives.
// The bench or host logic uses master; the scanner uses slave.
interface seven_seg_scan_mux_if #(
    parameter int N_DIGITS = 8
);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  lz_sup;
    logic                  load;
    logic [3:0]            hex_out;
    logic [N_DIGITS-1:0]   an;
    logic                  dp_out;
    logic [IDX_W-1:0]      digit_idx;

    modport master (
        output value, dp_in, digit_en, lz_sup, load,
        input  hex_out, an, dp_out, digit_idx
    );

    modport slave (
        input  value, dp_in, digit_en, lz_sup, load,
        output hex_out, an, dp_out, digit_idx
    );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display,
// with a blanking guard at the start of each digit slot and optional leading-zero suppression.
module seven_seg_scan_mux #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_seg_scan_mux_if.slave   bus
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic                DP_OFF   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic [CNT_W-1:0]             cnt_r;
    logic [IDX_W-1:0]             idx_r;
    logic [N_DIGITS-1:0][3:0]     nib_r;
    logic [N_DIGITS-1:0]          dp_r;
    logic [N_DIGITS-1:0]          en_r;
    logic [3:0]                   hex_out_r;
    logic [N_DIGITS-1:0]          an_r;
    logic                         dp_out_r;
    logic [IDX_W-1:0]             digit_idx_r;

    logic [CNT_W-1:0]             cnt_nxt_s;
    logic [IDX_W-1:0]             idx_nxt_s;
    logic                         in_blank_s;
    phase_t                       phase_s;
    logic                         supp_s;
    logic                         lit_s;
    logic [N_DIGITS-1:0]          an_act_s;
    logic                         dp_act_s;
    logic [N_DIGITS-1:0]          an_nxt_s;
    logic                         dp_nxt_s;
    logic [3:0]                   hex_nxt_s;

    // A digit is suppressed when it and every more-significant nibble are zero; digit 0 never is.
    function automatic logic is_suppressed(
        input logic [N_DIGITS-1:0][3:0] nib,
        input logic [IDX_W-1:0]         i,
        input logic                     sup
    );
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if ((IDX_W'(j) >= i) && (nib[j] != 4'h0)) begin
                nz = 1'b1;
            end
        end
        return sup && (i != {IDX_W{1'b0}}) && !nz;
    endfunction

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank_s = 1'b0;
        end else begin : g_blank
            assign in_blank_s = (cnt_r < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Slot counter and digit index next-state, wrapping exactly at the last digit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        idx_nxt_s = idx_r;
        if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Phase decode and next pin values for the current slot.
    always_comb begin
        phase_s   = PH_SHOW;
        an_act_s  = {N_DIGITS{1'b0}};
        dp_act_s  = 1'b0;
        supp_s    = is_suppressed(nib_r, idx_r, bus.lz_sup);
        lit_s     = en_r[idx_r] & ~supp_s;
        hex_nxt_s = nib_r[idx_r];
        if (in_blank_s) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_SHOW;
        end
        case (phase_s)
            PH_BLANK: begin
                an_act_s = {N_DIGITS{1'b0}};
                dp_act_s = 1'b0;
            end
            PH_SHOW: begin
                if (lit_s) begin
                    an_act_s = AN_ONE << idx_r;
                end else begin
                    an_act_s = {N_DIGITS{1'b0}};
                end
                // Suppressed digits stay fully dark, decimal point included.
                dp_act_s = lit_s & dp_r[idx_r];
            end
            default: begin
                an_act_s = {N_DIGITS{1'b0}};
                dp_act_s = 1'b0;
            end
        endcase
        an_nxt_s = an_act_s ^ AN_OFF;
        dp_nxt_s = dp_act_s ^ DP_OFF;
    end

    // Slot counter and digit index state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    // Shadow copy of the display data, refreshed whenever load is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            nib_r <= {(4*N_DIGITS){1'b0}};
            dp_r  <= {N_DIGITS{1'b0}};
            en_r  <= {N_DIGITS{1'b0}};
        end else if (bus.load) begin
            nib_r <= bus.value;
            dp_r  <= bus.dp_in;
            en_r  <= bus.digit_en;
        end else begin
            nib_r <= nib_r;
            dp_r  <= dp_r;
            en_r  <= en_r;
        end
    end

    // Registered pin drives, one cycle behind the counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_out_r   <= 4'h0;
            an_r        <= AN_OFF;
            dp_out_r    <= DP_OFF;
            digit_idx_r <= {IDX_W{1'b0}};
        end else begin
            hex_out_r   <= hex_nxt_s;
            an_r        <= an_nxt_s;
            dp_out_r    <= dp_nxt_s;
            digit_idx_r <= idx_r;
        end
    end

    assign bus.hex_out   = hex_out_r;
    assign bus.an        = an_r;
    assign bus.dp_out    = dp_out_r;
    assign bus.digit_idx = digit_idx_r;

endmodule
